// File: rtl/store_commit_buf_pkg.sv
// Shared constants for the store commit buffer and its age-priority match helper.
package store_commit_buf_pkg;

    localparam int STBUF_DEPTH = 16;
    localparam int STBUF_SEL   = $clog2(STBUF_DEPTH);
    localparam int STBUF_OFF_W = 2;

endpackage

// File: rtl/store_commit_buf_age_match.sv
// Rotated priority search: finds the youngest valid matching entry, where age is
// measured as the distance from the head slot.
module stbuf_age_match
    import store_commit_buf_pkg::*;
#(
    parameter int DEPTH = STBUF_DEPTH
) (
    input  logic [DEPTH-1:0]         match_i,
    input  logic [DEPTH-1:0]         valid_i,
    input  logic [$clog2(DEPTH)-1:0] head_i,
    output logic                     hit_o,
    output logic [$clog2(DEPTH)-1:0] idx_o
);

    localparam int SEL = $clog2(DEPTH);

    logic [SEL-1:0] slot_s;
    logic           cand_s;

    // Walk from oldest to youngest so the last candidate seen is the youngest.
    always_comb begin
        hit_o  = 1'b0;
        idx_o  = {SEL{1'b0}};
        slot_s = {SEL{1'b0}};
        cand_s = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            slot_s = head_i + SEL'(k);
            cand_s = match_i[slot_s] & valid_i[slot_s];
            hit_o  = hit_o | cand_s;
            idx_o  = cand_s ? slot_s : idx_o;
        end
    end

endmodule

// File: rtl/store_commit_buf_chk.sv
// Protocol and consistency checks for store_commit_buf; carries no functional logic.
module store_commit_buf_chk #(
    parameter int DEPTH = 16
) (
    input logic                     clk,
    input logic                     reset,
    input logic                     stcommit_i,
    input logic [$clog2(DEPTH):0]   cptr_i,
    input logic [$clog2(DEPTH):0]   tail_i,
    input logic                     hit_i,
    input logic [$clog2(DEPTH)-1:0] idx_i,
    input logic [DEPTH-1:0]         match_i,
    input logic [DEPTH-1:0]         valid_i
);

    // A commit with nothing left to commit is a ROB protocol violation.
    a_commit_has_entry: assert property (@(posedge clk) disable iff (reset)
        stcommit_i |-> (cptr_i != tail_i));

    // The selected forwarding slot must itself be a valid match.
    a_hit_idx_valid: assert property (@(posedge clk) disable iff (reset)
        hit_i |-> (match_i[idx_i] && valid_i[idx_i]));

endmodule

// File: rtl/store_commit_buf.sv
// In-order speculative store buffer with commit pointer, flush and in-order drain.
// Define STBUF_FORWARD_EN to enable store-to-load data forwarding.
module store_commit_buf
    import store_commit_buf_pkg::*;
#(
    parameter int DEPTH    = STBUF_DEPTH,
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc_en,
    input  logic [ADDR_LEN-1:0]      alloc_addr,
    input  logic [DATA_LEN-1:0]      alloc_data,
    output logic                     full,
    input  logic                     stcommit,
    input  logic                     prmiss,
    output logic                     mem_req,
    output logic [ADDR_LEN-1:0]      mem_addr,
    output logic [DATA_LEN-1:0]      mem_data,
    input  logic                     mem_ack,
    input  logic [ADDR_LEN-1:0]      ld_addr,
    output logic                     ld_conflict,
    output logic                     fwd_hit,
    output logic [DATA_LEN-1:0]      fwd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int SEL = $clog2(DEPTH);
    localparam logic [ADDR_LEN-1:0] WORD_MASK = {ADDR_LEN{1'b1}} << STBUF_OFF_W;

    logic [SEL:0]          head_q, cptr_q, tail_q;
    logic [SEL:0]          head_d, cptr_d, tail_d;
    logic [ADDR_LEN-1:0]   addr_q [DEPTH];
    logic [DATA_LEN-1:0]   data_q [DEPTH];
    logic [SEL:0]          occ_s;
    logic                  full_s, alloc_s, commit_s, drain_s;
    logic [DEPTH-1:0]      valid_s, match_s;
    logic                  hit_s;
    logic [SEL-1:0]        hit_idx_s;

    assign occ_s    = tail_q - head_q;
    assign full_s   = (occ_s == (SEL+1)'(DEPTH));
    assign commit_s = stcommit & (cptr_q != tail_q);
    assign drain_s  = (head_q != cptr_q) & mem_ack;
    // A flush in the same cycle wins over any new allocation.
    assign alloc_s  = alloc_en & ~full_s & ~prmiss;

    assign cptr_d = cptr_q + {{SEL{1'b0}}, commit_s};
    assign head_d = head_q + {{SEL{1'b0}}, drain_s};
    assign tail_d = prmiss ? cptr_d : (tail_q + {{SEL{1'b0}}, alloc_s});

    // Pointer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= {(SEL+1){1'b0}};
            cptr_q <= {(SEL+1){1'b0}};
            tail_q <= {(SEL+1){1'b0}};
        end else begin
            head_q <= head_d;
            cptr_q <= cptr_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage; contents are qualified by the pointers, so no reset is needed.
    always_ff @(posedge clk) begin
        if (alloc_s) begin
            addr_q[tail_q[SEL-1:0]] <= alloc_addr;
            data_q[tail_q[SEL-1:0]] <= alloc_data;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [SEL-1:0] off_s;
        assign off_s      = SEL'(i) - head_q[SEL-1:0];
        assign valid_s[i] = ({1'b0, off_s} < occ_s);
        assign match_s[i] = (((addr_q[i] ^ ld_addr) & WORD_MASK) == {ADDR_LEN{1'b0}});
    end

    stbuf_age_match #(.DEPTH(DEPTH)) u_age_match (
        .match_i (match_s),
        .valid_i (valid_s),
        .head_i  (head_q[SEL-1:0]),
        .hit_o   (hit_s),
        .idx_o   (hit_idx_s)
    );

    store_commit_buf_chk #(.DEPTH(DEPTH)) u_chk (
        .clk        (clk),
        .reset      (reset),
        .stcommit_i (stcommit),
        .cptr_i     (cptr_q),
        .tail_i     (tail_q),
        .hit_i      (hit_s),
        .idx_i      (hit_idx_s),
        .match_i    (match_s),
        .valid_i    (valid_s)
    );

    assign full        = full_s;
    assign count       = occ_s;
    assign empty       = (occ_s == {(SEL+1){1'b0}});
    assign mem_req     = (head_q != cptr_q);
    assign mem_addr    = addr_q[head_q[SEL-1:0]];
    assign mem_data    = data_q[head_q[SEL-1:0]];
    assign ld_conflict = hit_s;

`ifdef STBUF_FORWARD_EN
    assign fwd_hit  = hit_s;
    assign fwd_data = hit_s ? data_q[hit_idx_s] : {DATA_LEN{1'b0}};
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = {DATA_LEN{1'b0}};
`endif

endmodule

// File: tb/tb_store_commit_buf.sv
// Directed bench for store_commit_buf with a queue-based scoreboard of buffered stores.
module tb_store_commit_buf;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_en;
    logic [31:0] alloc_addr, alloc_data;
    logic        full, stcommit, prmiss;
    logic        mem_req, mem_ack;
    logic [31:0] mem_addr, mem_data;
    logic [31:0] ld_addr;
    logic        ld_conflict, fwd_hit;
    logic [31:0] fwd_data;
    logic [4:0]  count;
    logic        empty;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } st_t;

    st_t sb[$];
    int  ncommit = 0;
    int  checks  = 0;
    int  errors  = 0;

    store_commit_buf dut (
        .clk(clk), .reset(reset),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .alloc_data(alloc_data),
        .full(full), .stcommit(stcommit), .prmiss(prmiss),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle, advance the model, then clear one-shot controls.
    task automatic step();
        logic exp_req, accept;
        @(negedge clk);
        exp_req = (ncommit > 0);
        chk("mem_req", mem_req, exp_req);
        chk("count", count, sb.size());
        chk("empty", empty, sb.size() == 0);
        chk("full", full, sb.size() == 16);
        accept = alloc_en && (sb.size() < 16) && !prmiss;
        if (exp_req && mem_ack) begin
            chk("drain_addr", mem_addr, sb[0].a);
            chk("drain_data", mem_data, sb[0].d);
            void'(sb.pop_front());
            ncommit--;
        end
        if (stcommit && ncommit < sb.size()) ncommit++;
        if (prmiss) while (sb.size() > ncommit) void'(sb.pop_back());
        if (accept) sb.push_back('{a: alloc_addr, d: alloc_data});
        @(posedge clk);
        #1;
        alloc_en = 1'b0;
        stcommit = 1'b0;
        prmiss   = 1'b0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        alloc_en   = 1'b1;
        alloc_addr = a;
        alloc_data = d;
        step();
    endtask

    task automatic commit();
        stcommit = 1'b1;
        step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        alloc_en = 1'b0;
        stcommit = 1'b0;
        prmiss   = 1'b0;
        sb.delete();
        ncommit = 0;
    endtask

    task automatic chk_ld(input logic [31:0] a);
        logic        exp_c;
        logic [31:0] exp_d;
        exp_c   = 1'b0;
        exp_d   = 32'h0;
        ld_addr = a;
        #1;
        foreach (sb[k]) begin
            if (sb[k].a[31:2] == a[31:2]) begin
                exp_c = 1'b1;
                exp_d = sb[k].d;
            end
        end
        chk("ld_conflict", ld_conflict, exp_c);
`ifdef STBUF_FORWARD_EN
        chk("fwd_hit", fwd_hit, exp_c);
        chk("fwd_data", fwd_data, exp_d);
`else
        chk("fwd_hit", fwd_hit, 1'b0);
        chk("fwd_data", fwd_data, 32'h0);
`endif
    endtask

    initial begin
        reset = 1'b1; alloc_en = 1'b0; alloc_addr = 32'h0; alloc_data = 32'h0;
        stcommit = 1'b0; prmiss = 1'b0; mem_ack = 1'b0; ld_addr = 32'h0;
        repeat (2) @(posedge clk);
        do_reset();

        // Reset state
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_count", count, 5'd0);
        chk_ld(32'h0);

        // Basic in-order drain
        mem_ack = 1'b1;
        push(32'h100, 32'hA);
        push(32'h104, 32'hB);
        push(32'h108, 32'hC);
        commit();
        commit();
        commit();
        repeat (3) step();
        chk("basic_empty", empty, 1'b1);

        // Flush: four stores, one committed, then mispredict
        mem_ack = 1'b0;
        push(32'h300, 32'h30);
        push(32'h304, 32'h31);
        push(32'h308, 32'h32);
        push(32'h30C, 32'h33);
        commit();
        prmiss = 1'b1;
        step();
        chk("flush_count", count, 5'd1);
        push(32'h400, 32'h40);
        commit();
        mem_ack = 1'b1;
        repeat (3) step();
        chk("flush_empty", empty, 1'b1);

        // Full and wrap
        do_reset();
        mem_ack = 1'b0;
        for (int i = 0; i < 17; i++) push(32'h1000 + 32'(4 * i), 32'(i));
        chk("full_flag", full, 1'b1);
        chk("full_count", count, 5'd16);
        chk_ld(32'h103C);
        for (int i = 0; i < 16; i++) commit();
        for (int j = 0; j < 48; j++) begin
            mem_ack = j[0];
            if (j < 24) begin
                alloc_en   = 1'b1;
                alloc_addr = 32'h2000 + 32'(4 * j);
                alloc_data = 32'h500 + 32'(j);
            end
            stcommit = (ncommit < sb.size());
            chk("count_bound", count <= 5'd16, 1'b1);
            step();
        end
        chk_ld(32'h2050);
        mem_ack = 1'b1;
        for (int j = 0; j < 64 && sb.size() > 0; j++) begin
            stcommit = (ncommit < sb.size());
            step();
        end
        chk("wrap_empty", empty, 1'b1);

        // Forwarding, youngest match wins
        do_reset();
        mem_ack = 1'b0;
        push(32'h200, 32'h1);
        push(32'h200, 32'h2);
        chk_ld(32'h202);
        chk_ld(32'h204);
        commit();
        mem_ack = 1'b1;
        step();
        chk_ld(32'h200);

        // Simultaneous alloc, commit, drain and flush
        do_reset();
        mem_ack = 1'b0;
        push(32'h600, 32'h60);
        push(32'h604, 32'h61);
        commit();
        alloc_en = 1'b1; alloc_addr = 32'h608; alloc_data = 32'h62;
        stcommit = 1'b1; mem_ack = 1'b1; prmiss = 1'b1;
        step();
        chk("sim_count", count, 5'd1);
        chk("sim_mem_req", mem_req, 1'b1);
        chk("sim_mem_addr", mem_addr, 32'h604);
        step();
        chk("sim_empty", empty, 1'b1);

        // Reset mid-handshake
        mem_ack = 1'b0;
        push(32'h700, 32'h70);
        commit();
        step();
        do_reset();
        chk("rmh_mem_req", mem_req, 1'b0);
        chk("rmh_count", count, 5'd0);
        chk("rmh_empty", empty, 1'b1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_commit_buf.md
# store_commit_buf

Store buffer on the load/store path, fed by the load/store execution unit and by the reorder buffer's `stcommit`/`prmiss` outputs. Executed stores are held speculatively in program order, marked committed one per `stcommit` pulse, and drained in order to data memory through a req/ack handshake. Uncommitted entries are discarded on `prmiss`. Loads may optionally forward data from buffered stores.

## Interface
Parameters:
- `DEPTH`, 16: number of entries; must be a power of two and at least 2.
- `ADDR_LEN`, 32: store address width.
- `DATA_LEN`, 32: store data width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `alloc_en` in 1: an executed store is written this cycle; stores arrive in program order.
- `alloc_addr` in ADDR_LEN: store byte address (word-aligned).
- `alloc_data` in DATA_LEN: store data.
- `full` out 1: no free entry; `alloc_en` is ignored while `full` is high.
- `stcommit` in 1: ROB commits the oldest uncommitted store; at most one per cycle.
- `prmiss` in 1: branch mispredict; flushes every uncommitted entry.
- `mem_req` out 1: drain request for the head entry.
- `mem_addr` out ADDR_LEN: head address; stable while `mem_req` is high.
- `mem_data` out DATA_LEN: head data; stable while `mem_req` is high.
- `mem_ack` in 1: memory accepted the request this cycle.
- `ld_addr` in ADDR_LEN: address of the load being issued.
- `ld_conflict` out 1: any valid entry matches `ld_addr[ADDR_LEN-1:2]`.
- `fwd_hit` out 1: forwarding data is valid.
- `fwd_data` out DATA_LEN: data from the youngest matching entry.
- `count` out log2(DEPTH)+1: number of valid entries.
- `empty` out 1: `count == 0`; used by fences.

## Operation
- **Pointers.** Three pointers, each log2(DEPTH)+1 bits wide; the MSB is a wrap bit.
  - `head`: oldest entry.
  - `cptr`: first uncommitted entry.
  - `tail`: next free slot.
  - Invariant: head ≤ cptr ≤ tail, in modular order.
- **Derived flags.**
  - `full` = (tail − head == DEPTH).
  - Entry i is committed when it lies in [head, cptr).
- **Allocate.** When `alloc_en` and not `full`: write addr/data at `tail`, then `tail++`.
- **Commit.** When `stcommit` and cptr ≠ tail: `cptr++`.
  - `stcommit` with cptr == tail is a protocol violation. It is ignored and flagged by an assertion.
- **Flush.** On `prmiss`: `tail` ← `cptr` after that cycle's commit is applied.
  - Any `alloc_en` in the same cycle is dropped.
  - Contract: `prmiss` is raised only when every older store has already been committed or receives `stcommit` in that same cycle.
- **Drain.**
  - `mem_req` = (head ≠ cptr), i.e. the head entry is committed. `mem_addr`/`mem_data` come from `head`.
  - On `mem_req & mem_ack`: `head++`.
  - `mem_ack` without `mem_req` is ignored.
- **Simultaneous events.** Alloc, commit, drain and flush all resolve in one cycle. `count` is updated as tail_next − head_next.
- **Full while draining.** `full` is computed from the current state. An alloc is rejected even if a drain frees a slot in the same cycle.
- **Load match.**
  - An entry matches on `addr[ADDR_LEN-1:2]`. Both committed and uncommitted entries participate.
  - An entry being allocated in the current cycle is not visible.
  - The youngest matching entry wins; a sub-module performs the age-priority search.

## Timing
- **Reset.** The cycle after `reset`:
  - head = cptr = tail = 0.
  - Outputs: `full` 0, `empty` 1, `count` 0, `mem_req` 0, `ld_conflict` 0, `fwd_hit` 0, `fwd_data` 0.
- **Reset mid-handshake.** An outstanding `mem_req` is dropped without completing; the memory side tolerates this.
- **Allocate.** An allocated entry is visible to match logic and `count` on the next cycle.
- **Commit to request.** `stcommit` in cycle N gives `mem_req` high in cycle N+1 if that entry is at head.
- **Drain rate.** With `mem_ack` tied high, throughput is one entry per cycle.
- **Combinational paths.** `mem_req`, `full`, `empty` and `count` are decoded from registered state only. `ld_conflict`/`fwd_*` are combinational from `ld_addr` and registered state.
- **Wrap.** Correct across pointer wrap; the wrap bits distinguish full from empty.

## Configuration
- **`STBUF_FORWARD_EN` defined:** `fwd_hit` = `ld_conflict`, and `fwd_data` = data of the youngest match.
- **`STBUF_FORWARD_EN` undefined:**
  - `fwd_hit` is tied to 0 and `fwd_data` to 0.
  - The data-select mux is removed.
  - `ld_conflict` remains, and the load unit stalls on it.

## Structure
- **Shared constants** go in the shared constants header: `STBUF_DEPTH`, `STBUF_SEL` (log2 depth), and the word-offset width (2).
- **Sub-module** `stbuf_age_match`:
  - Inputs: per-entry match vector, valid vector, `head`.
  - Outputs: `hit` and the youngest-match index.
  - Implements the rotated priority search relative to `head`.

## Test plan
- **Basic in-order drain:** alloc 3 stores (0x100/0xA, 0x104/0xB, 0x108/0xC), then 3 `stcommit`, with `mem_ack` = 1 → `mem_req` on 3 consecutive cycles with addrs 0x100, 0x104, 0x108; then `empty` = 1.
- **Flush:** alloc 4, commit 1, `prmiss` → `count` = 1; the drain emits only the first store; a later alloc lands at the old `cptr` slot.
- **Full and wrap:** fill 16 entries → `full` = 1; the 17th alloc is dropped. Commit all, drain all with `mem_ack` every other cycle, refill across the wrap → data order is preserved and `count` never exceeds 16.
- **Forwarding:** stores 0x200/1 then 0x200/2, load 0x202 → `ld_conflict` = 1. With `STBUF_FORWARD_EN`: `fwd_hit` = 1 and `fwd_data` = 2. Without it: `fwd_hit` = 0.
- **Simultaneous events:** alloc, `stcommit`, `mem_ack` and `prmiss` in one cycle → commit applied, alloc dropped, head advances, tail = cptr.
- **Reset mid-handshake:** `reset` while `mem_req` = 1 and `mem_ack` = 0 → next cycle `mem_req` = 0, `count` = 0, `empty` = 1.
